// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped console transmitter. Snoops the MEM-stage store
//               bus. Bytes stored to TX_ADDR are queued in a small FIFO and
//               sent as 8N1, LSB first. A status word at STATUS_ADDR reports
//               busy/empty/full/count/dropCnt.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
  parameter logic [7:0] TX_ADDR      = 8'hFF,
  parameter logic [7:0] STATUS_ADDR  = 8'hFE,
  parameter int         DEPTH        = 8,
  parameter int         CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        wren,
  input  logic [7:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] rdData,
  output logic        tx,
  output logic        busy
);

  // Pointer and bit-timer widths; guarded so degenerate sizes stay >= 1 bit.
  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Count is always 4 bits so it drops straight into status[7:4].
  localparam logic [3:0]      c_DEPTH     = 4'(DEPTH);
  localparam logic [3:0]      c_CNT_ONE   = 4'd1;
  localparam logic [c_PW-1:0] c_PTR_ONE   = c_PW'(1);
  localparam logic [c_TW-1:0] c_TIMER_ONE = c_TW'(1);
  localparam logic [c_TW-1:0] c_BIT_LAST  = c_TW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]      c_DROP_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic              r_tx;
  logic [7:0]        r_shift;
  logic [c_TW-1:0]   r_timer;
  logic [2:0]        r_bit_idx;

  logic [7:0]        r_mem [DEPTH];
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [3:0]        r_count;
  logic [7:0]        r_drop_cnt;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  state_t            w_state_nxt;
  logic              w_tx_bit;
  logic [7:0]        w_shift_nxt;
  logic [c_TW-1:0]   w_timer_nxt;
  logic [2:0]        w_bit_idx_nxt;
  logic              w_bit_done;

  logic              w_empty;
  logic              w_full;
  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [31:0]       w_status;

  // Only the low byte of the store data is meaningful to this peripheral.
  logic              w_unused_din;
  assign w_unused_din = ^din[31:8];

  // ---------------------------------------------------------------------------
  // FIFO flags and push/drop decision
  // ---------------------------------------------------------------------------
  assign w_empty    = (r_count == 4'd0);
  assign w_full     = (r_count == c_DEPTH);
  assign w_push_req = wren && (addr == TX_ADDR);
  // A full FIFO can still accept a byte when the transmitter pops the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_push;

  assign w_bit_done = (r_timer == c_BIT_LAST);

  // FSM state register and transmit datapath registers
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_shift   <= 8'h00;
      r_timer   <= '0;
      r_bit_idx <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_bit;
      r_shift   <= w_shift_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_idx <= w_bit_idx_nxt;
    end
  end

  // Next-state, line level for the current state, and FIFO pop request
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_bit      = 1'b1;
    w_shift_nxt   = r_shift;
    w_timer_nxt   = r_timer + c_TIMER_ONE;
    w_bit_idx_nxt = r_bit_idx;
    w_pop         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_bit    = 1'b1;
        w_timer_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        w_tx_bit = 1'b0;
        if (w_bit_done) begin
          w_timer_nxt   = '0;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = S_DATA;
        end
      end

      S_DATA: begin
        w_tx_bit = r_shift[0];
        if (w_bit_done) begin
          w_timer_nxt = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end

      S_STOP: begin
        w_tx_bit = 1'b1;
        if (w_bit_done) begin
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din[7:0];
    end
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clock) begin
    if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 4'd0;
      r_drop_cnt <= 8'h00;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop_cnt != c_DROP_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: status reflects pre-edge register state
  // ---------------------------------------------------------------------------
  assign busy     = (r_state != S_IDLE);
  assign tx       = r_tx;
  assign w_status = {16'h0000, r_drop_cnt, r_count, 1'b0, w_full, w_empty, busy};
  assign rdData   = (addr == STATUS_ADDR) ? w_status : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Self-checking bench for mmio_uart_tx (DEPTH=4, CLKS_PER_BIT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

  logic        clock;
  logic        clear;
  logic        wren;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] rdData;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx #(
    .TX_ADDR     (8'hFF),
    .STATUS_ADDR (8'hFE),
    .DEPTH       (4),
    .CLKS_PER_BIT(4)
  ) dut (
    .clock (clock),
    .clear (clear),
    .wren  (wren),
    .addr  (addr),
    .din   (din),
    .rdData(rdData),
    .tx    (tx),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wren;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_rd;
    logic        exp_tx;
    logic        exp_busy;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] ovf_b  [7];
  logic [7:0] wrap_b [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at the sample time (negedge) where index first_i of the frame is seen.
  // Index 0 is the first sample with tx low; each bit occupies 4 samples;
  // index 39 is the IDLE cycle, index 40 is one more idle-level sample.
  // Returns at the sample where a back-to-back next frame's start bit is visible.
  task automatic check_frame(input logic [7:0] b, input int first_i, input int inj_i,
                             input logic [7:0] inj_b, input bit chk_full);
    logic [9:0] pat;
    logic       exp_tx;
    pat = {1'b1, b, 1'b0};
    for (int i = first_i; i <= 40; i++) begin
      wren = 1'b0;
      addr = 8'hFE;
      #1;
      exp_tx = (i == 40) ? 1'b1 : pat[i / 4];
      chk($sformatf("tx byte %h sample %0d", b, i), 32'(tx), 32'(exp_tx));
      if (i <= 39) chk($sformatf("busy byte %h sample %0d", b, i), 32'(busy), 32'(i < 39));
      if (chk_full && i == 39) chk("status full before pop+push", rdData, 32'h0000_0144);
      if (chk_full && i == 40) chk("status full after pop+push", rdData, 32'h0000_0145);
      if (i == inj_i) begin
        wren = 1'b1;
        addr = 8'hFF;
        din  = {24'h0, inj_b};
      end
      @(negedge clock);
    end
  endtask

  initial begin
    // store elsewhere, store to status, read status, push, then watch the pop
    tbl[0] = '{1'b1, 8'h10, 32'h0000_0041, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'hFE, 32'h0000_0041, 32'h0000_0002, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'hFE, 32'h0000_0000, 32'h0000_0002, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'hFF, 32'hDEAD_BE41, 32'h0000_0000, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'hFE, 32'h0000_0000, 32'h0000_0010, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'hFE, 32'h0000_0000, 32'h0000_0003, 1'b1, 1'b1};

    ovf_b[0] = 8'h01; ovf_b[1] = 8'h80; ovf_b[2] = 8'h3C; ovf_b[3] = 8'hA5;
    ovf_b[4] = 8'h7E; ovf_b[5] = 8'hEE; ovf_b[6] = 8'h96;
    for (int k = 0; k < 12; k++) wrap_b[k] = 8'(8'h13 * (k + 1) + k);

    clear = 1'b1;
    wren  = 1'b0;
    addr  = 8'hFE;
    din   = 32'h0;

    // Reset held for two clocks
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("reset tx", 32'(tx), 32'h1);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset status", rdData, 32'h0000_0002);
    clear = 1'b0;
    @(negedge clock);

    // Table vectors: address decode, status read, first-transaction latency
    for (int v = 0; v < 6; v++) begin
      wren = tbl[v].wren;
      addr = tbl[v].addr;
      din  = tbl[v].din;
      #1;
      chk($sformatf("vec%0d rdData", v), rdData, tbl[v].exp_rd);
      chk($sformatf("vec%0d tx", v), 32'(tx), 32'(tbl[v].exp_tx));
      chk($sformatf("vec%0d busy", v), 32'(busy), 32'(tbl[v].exp_busy));
      @(negedge clock);
    end

    // Single byte 0x41: tx low 2 clocks after the write edge, 40 busy clocks
    check_frame(8'h41, 0, -1, 8'h00, 1'b0);
    wren = 1'b0;
    addr = 8'hFE;
    #1;
    chk("single idle status", rdData, 32'h0000_0002);
    chk("single idle busy", 32'(busy), 32'h0);

    // Overflow: six consecutive writes while idle
    for (int k = 0; k < 6; k++) begin
      wren = 1'b1;
      addr = 8'hFF;
      din  = {24'h0, ovf_b[k]};
      @(negedge clock);
    end
    wren = 1'b0;
    addr = 8'hFE;
    #1;
    chk("overflow status", rdData, 32'h0000_0145);
    // First frame is 3 samples in; write while full exactly when FSM pops
    check_frame(ovf_b[0], 3, 39, ovf_b[6], 1'b1);
    for (int k = 1; k < 5; k++) check_frame(ovf_b[k], 0, -1, 8'h00, 1'b0);
    check_frame(ovf_b[6], 0, -1, 8'h00, 1'b0);
    wren = 1'b0;
    addr = 8'hFE;
    #1;
    chk("after overflow drain status", rdData, 32'h0000_0102);

    // Back-to-back 0x55, 0xAA, then 12 more bytes fed during each frame
    wren = 1'b1; addr = 8'hFF; din = 32'h55;
    @(negedge clock);
    wren = 1'b1; addr = 8'hFF; din = 32'hAA;
    @(negedge clock);
    wren = 1'b0; addr = 8'hFE;
    @(negedge clock);
    check_frame(8'h55, 0, 20, wrap_b[0], 1'b0);
    check_frame(8'hAA, 0, 20, wrap_b[1], 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (k + 2 < 12) check_frame(wrap_b[k], 0, 20, wrap_b[k + 2], 1'b0);
      else            check_frame(wrap_b[k], 0, -1, 8'h00, 1'b0);
    end
    wren = 1'b0;
    addr = 8'hFE;
    #1;
    chk("after wrap run status", rdData, 32'h0000_0102);

    // Reset during DATA bit 3 of 0xC3 with two more bytes queued
    wren = 1'b1; addr = 8'hFF; din = 32'hC3;
    @(negedge clock);
    din = 32'h11;
    @(negedge clock);
    din = 32'h22;
    @(negedge clock);
    wren = 1'b0;
    addr = 8'hFE;
    repeat (16) @(negedge clock);
    #1;
    chk("midframe tx bit3", 32'(tx), 32'h0);
    chk("midframe busy", 32'(busy), 32'h1);
    clear = 1'b1;
    @(negedge clock);
    #1;
    chk("post-clear tx", 32'(tx), 32'h1);
    chk("post-clear busy", 32'(busy), 32'h0);
    chk("post-clear status", rdData, 32'h0000_0002);
    clear = 1'b0;
    begin
      int lows;
      lows = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clock);
        if (tx !== 1'b1 || busy !== 1'b0) lows++;
      end
      chk("no transmit after clear", 32'(lows), 32'h0);
    end
    #1;
    chk("final status", rdData, 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
